// File: rtl/hazard_pkg.sv
// Shared encodings for the hazard / forwarding controller: operand source
// selects, FSM states and the width of the load-use down-counter.
package hazard_pkg;

    // Operand source select driven into the EX-stage operand muxes.
    typedef logic [1:0] fwd_sel_t;

    localparam fwd_sel_t FWD_RF  = 2'b00;  // value read from the register file
    localparam fwd_sel_t FWD_WB  = 2'b01;  // MEM/WB pipeline result
    localparam fwd_sel_t FWD_MEM = 2'b10;  // EX/MEM pipeline result

    // Controller states. 2'b11 is unused and recovers to RUN.
    typedef enum logic [1:0] {
        ST_RUN   = 2'b00,
        ST_STALL = 2'b01,
        ST_FLUSH = 2'b10
    } state_t;

    // Load latency is at most 4, so the remaining-stall counter holds 0..3.
    localparam int LAT_CNT_W = 2;

endpackage

// File: rtl/fwd_match.sv
// Per-operand producer comparison. It reports which pipeline stage, if any,
// holds the newest value for one source operand. The EX producer wins over
// MEM because it is the younger write to the same register.
module fwd_match
    import hazard_pkg::*;
#(
    parameter int REG_ADDR_W = 5
) (
    input  logic [REG_ADDR_W-1:0] rs,
    input  logic                  used,
    input  logic [REG_ADDR_W-1:0] ex_rd,
    input  logic                  ex_regwrite,
    input  logic [REG_ADDR_W-1:0] mem_rd,
    input  logic                  mem_regwrite,
    output fwd_sel_t              sel,
    output logic                  ex_hit
);

    logic mem_hit;

    // Register 0 is hard-wired to zero, so a write to it never forwards.
    always_comb begin
        ex_hit  = used && ex_regwrite  && (ex_rd  != '0) && (rs == ex_rd);
        mem_hit = used && mem_regwrite && (mem_rd != '0) && (rs == mem_rd);
        sel     = FWD_RF;
        if (ex_hit) begin
            sel = FWD_MEM;
        end else if (mem_hit) begin
            sel = FWD_WB;
        end
    end

endmodule

// File: rtl/hazard_fwd_ctrl.sv
// Pipeline hazard and forwarding controller. It computes registered forward
// selects for the EX stage, stalls for LOAD_LAT cycles on a load-use hazard,
// and squashes IF/ID for one cycle after a taken branch. The control outputs
// depend only on the registered state.
module hazard_fwd_ctrl
    import hazard_pkg::*;
#(
    parameter int REG_ADDR_W = 5,
    parameter int NUM_SRC    = 2,
    parameter int LOAD_LAT   = 1,
    parameter int CNT_W      = 16
) (
    input  logic                          clk,
    input  logic                          rst_n,
    input  logic [NUM_SRC*REG_ADDR_W-1:0] id_rs,
    input  logic [NUM_SRC-1:0]            id_rs_used,
    input  logic [REG_ADDR_W-1:0]         ex_rd,
    input  logic [REG_ADDR_W-1:0]         mem_rd,
    input  logic                          ex_regwrite,
    input  logic                          ex_memread,
    input  logic                          mem_regwrite,
    input  logic                          ex_branch_taken,
    output logic [2*NUM_SRC-1:0]          fwd_sel,
    output logic                          pc_hold,
    output logic                          if_id_hold,
    output logic                          id_ex_bubble,
    output logic                          if_id_flush,
    output logic [CNT_W-1:0]              stall_cycles
);

    localparam logic [LAT_CNT_W-1:0] STALL_LOAD = LAT_CNT_W'(LOAD_LAT - 1);

    logic [2*NUM_SRC-1:0]   match_sel;
    logic [NUM_SRC-1:0]     ex_hit;
    logic                   load_use;

    state_t                 state_reg;
    state_t                 state_next;
    logic [LAT_CNT_W-1:0]   cnt_reg;
    logic [LAT_CNT_W-1:0]   cnt_next;
    logic [2*NUM_SRC-1:0]   fwd_sel_reg;
    logic [2*NUM_SRC-1:0]   fwd_sel_next;
    logic [CNT_W-1:0]       stall_cycles_reg;
    logic [CNT_W-1:0]       stall_cycles_next;

    // One independent comparator per source operand.
    generate
        for (genvar gi = 0; gi < NUM_SRC; gi++) begin : g_match
            fwd_match #(
                .REG_ADDR_W (REG_ADDR_W)
            ) u_fwd_match (
                .rs           (id_rs[gi*REG_ADDR_W +: REG_ADDR_W]),
                .used         (id_rs_used[gi]),
                .ex_rd        (ex_rd),
                .ex_regwrite  (ex_regwrite),
                .mem_rd       (mem_rd),
                .mem_regwrite (mem_regwrite),
                .sel          (match_sel[gi*2 +: 2]),
                .ex_hit       (ex_hit[gi])
            );
        end
    endgenerate

    // A load in EX whose destination is read by the ID instruction cannot be forwarded yet.
    assign load_use = ex_memread && (|ex_hit);

    // State, counter and output registers; reset clears everything immediately.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_reg        <= ST_RUN;
            cnt_reg          <= '0;
            fwd_sel_reg      <= '0;
            stall_cycles_reg <= '0;
        end else begin
            state_reg        <= state_next;
            cnt_reg          <= cnt_next;
            fwd_sel_reg      <= fwd_sel_next;
            stall_cycles_reg <= stall_cycles_next;
        end
    end

    // Next-state and counter logic; a taken branch overrides everything, including a stall.
    always_comb begin
        state_next = state_reg;
        cnt_next   = cnt_reg;
        case (state_reg)
            ST_RUN: begin
                if (ex_branch_taken) begin
                    state_next = ST_FLUSH;
                end else if (load_use) begin
                    state_next = ST_STALL;
                    cnt_next   = STALL_LOAD;
                end
            end
            ST_STALL: begin
                if (ex_branch_taken) begin
                    state_next = ST_FLUSH;
                    cnt_next   = '0;
                end else if (cnt_reg == '0) begin
                    state_next = ST_RUN;
                end else begin
                    cnt_next   = cnt_reg - 1'b1;
                end
            end
            ST_FLUSH: begin
                state_next = ex_branch_taken ? ST_FLUSH : ST_RUN;
            end
            default: begin
                state_next = ST_RUN;
                cnt_next   = '0;
            end
        endcase
    end

    // Forward selects are only meaningful when the next cycle is a normal RUN cycle.
    always_comb begin
        fwd_sel_next = '0;
        if (state_next == ST_RUN) begin
            fwd_sel_next = match_sel;
        end
    end

    // Count cycles spent stalled, pinning at the maximum instead of wrapping.
    always_comb begin
        stall_cycles_next = stall_cycles_reg;
        if ((state_reg == ST_STALL) && (stall_cycles_reg != '1)) begin
            stall_cycles_next = stall_cycles_reg + 1'b1;
        end
    end

    // Moore control outputs decoded from the registered state.
    always_comb begin
        pc_hold      = 1'b0;
        if_id_hold   = 1'b0;
        id_ex_bubble = 1'b0;
        if_id_flush  = 1'b0;
        case (state_reg)
            ST_STALL: begin
                pc_hold      = 1'b1;
                if_id_hold   = 1'b1;
                id_ex_bubble = 1'b1;
            end
            ST_FLUSH: begin
                if_id_flush  = 1'b1;
                id_ex_bubble = 1'b1;
            end
            default: begin
            end
        endcase
    end

    assign fwd_sel      = fwd_sel_reg;
    assign stall_cycles = stall_cycles_reg;

endmodule

// File: tb/tb_hazard_fwd_ctrl.sv
// Directed bench for hazard_fwd_ctrl. The main instance uses LOAD_LAT=3 and a
// 16-bit counter; a second instance with LOAD_LAT=1 and a 4-bit counter
// exercises counter saturation.
module tb_hazard_fwd_ctrl;

    logic        clk;
    logic        rst_n;

    logic [9:0]  id_rs;
    logic [1:0]  id_rs_used;
    logic [4:0]  ex_rd;
    logic [4:0]  mem_rd;
    logic        ex_regwrite;
    logic        ex_memread;
    logic        mem_regwrite;
    logic        ex_branch_taken;
    logic [3:0]  fwd_sel;
    logic        pc_hold;
    logic        if_id_hold;
    logic        id_ex_bubble;
    logic        if_id_flush;
    logic [15:0] stall_cycles;

    logic [9:0]  s_id_rs;
    logic [1:0]  s_id_rs_used;
    logic [4:0]  s_ex_rd;
    logic [4:0]  s_mem_rd;
    logic        s_ex_regwrite;
    logic        s_ex_memread;
    logic        s_mem_regwrite;
    logic        s_ex_branch_taken;
    logic [3:0]  s_fwd_sel;
    logic        s_pc_hold;
    logic        s_if_id_hold;
    logic        s_id_ex_bubble;
    logic        s_if_id_flush;
    logic [3:0]  s_stall_cycles;

    int tests = 0;
    int fails = 0;

    typedef struct {
        string       tag;
        logic [3:0]  fwd;
        logic        hold;
        logic        bub;
        logic        fl;
        logic [15:0] sc;
    } exp_t;

    exp_t sb[$];

    hazard_fwd_ctrl #(
        .REG_ADDR_W (5),
        .NUM_SRC    (2),
        .LOAD_LAT   (3),
        .CNT_W      (16)
    ) dut (
        .clk             (clk),
        .rst_n           (rst_n),
        .id_rs           (id_rs),
        .id_rs_used      (id_rs_used),
        .ex_rd           (ex_rd),
        .mem_rd          (mem_rd),
        .ex_regwrite     (ex_regwrite),
        .ex_memread      (ex_memread),
        .mem_regwrite    (mem_regwrite),
        .ex_branch_taken (ex_branch_taken),
        .fwd_sel         (fwd_sel),
        .pc_hold         (pc_hold),
        .if_id_hold      (if_id_hold),
        .id_ex_bubble    (id_ex_bubble),
        .if_id_flush     (if_id_flush),
        .stall_cycles    (stall_cycles)
    );

    hazard_fwd_ctrl #(
        .REG_ADDR_W (5),
        .NUM_SRC    (2),
        .LOAD_LAT   (1),
        .CNT_W      (4)
    ) dut_sat (
        .clk             (clk),
        .rst_n           (rst_n),
        .id_rs           (s_id_rs),
        .id_rs_used      (s_id_rs_used),
        .ex_rd           (s_ex_rd),
        .mem_rd          (s_mem_rd),
        .ex_regwrite     (s_ex_regwrite),
        .ex_memread      (s_ex_memread),
        .mem_regwrite    (s_mem_regwrite),
        .ex_branch_taken (s_ex_branch_taken),
        .fwd_sel         (s_fwd_sel),
        .pc_hold         (s_pc_hold),
        .if_id_hold      (s_if_id_hold),
        .id_ex_bubble    (s_id_ex_bubble),
        .if_id_flush     (s_if_id_flush),
        .stall_cycles    (s_stall_cycles)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic cmp(input string tag, input logic [15:0] got, input logic [15:0] exp);
        tests++;
        assert (got === exp) else begin
            fails++;
            $error("FAIL %s: observed %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic set_in(input logic [4:0] rs2, input logic [4:0] rs1, input logic [1:0] used,
                          input logic [4:0] erd, input logic erw, input logic emr,
                          input logic [4:0] mrd, input logic mrw, input logic br);
        id_rs           = {rs2, rs1};
        id_rs_used      = used;
        ex_rd           = erd;
        ex_regwrite     = erw;
        ex_memread      = emr;
        mem_rd          = mrd;
        mem_regwrite    = mrw;
        ex_branch_taken = br;
    endtask

    task automatic push_exp(input string tag, input logic [3:0] fwd, input logic hold,
                            input logic bub, input logic fl, input logic [15:0] sc);
        exp_t e;
        e.tag  = tag;
        e.fwd  = fwd;
        e.hold = hold;
        e.bub  = bub;
        e.fl   = fl;
        e.sc   = sc;
        sb.push_back(e);
    endtask

    task automatic check_next();
        exp_t e;
        e = sb.pop_front();
        $display("[TB] %s: fwd_sel=%b hold=%b/%b bubble=%b flush=%b stall_cycles=%0d",
                 e.tag, fwd_sel, pc_hold, if_id_hold, id_ex_bubble, if_id_flush, stall_cycles);
        cmp({e.tag, ".fwd_sel"},      {12'd0, fwd_sel},      {12'd0, e.fwd});
        cmp({e.tag, ".pc_hold"},      {15'd0, pc_hold},      {15'd0, e.hold});
        cmp({e.tag, ".if_id_hold"},   {15'd0, if_id_hold},   {15'd0, e.hold});
        cmp({e.tag, ".id_ex_bubble"}, {15'd0, id_ex_bubble}, {15'd0, e.bub});
        cmp({e.tag, ".if_id_flush"},  {15'd0, if_id_flush},  {15'd0, e.fl});
        cmp({e.tag, ".stall_cycles"}, stall_cycles,          e.sc);
    endtask

    // Push the expectation for the state after the coming edge, then clock and compare.
    task automatic step(input string tag, input logic [3:0] fwd, input logic hold,
                        input logic bub, input logic fl, input logic [15:0] sc);
        push_exp(tag, fwd, hold, bub, fl, sc);
        @(posedge clk);
        #1;
        check_next();
    endtask

    initial begin
        rst_n = 1'b0;
        set_in(5'd0, 5'd0, 2'b00, 5'd0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b0);
        s_id_rs           = '0;
        s_id_rs_used      = '0;
        s_ex_rd           = '0;
        s_mem_rd          = '0;
        s_ex_regwrite     = 1'b0;
        s_ex_memread      = 1'b0;
        s_mem_regwrite    = 1'b0;
        s_ex_branch_taken = 1'b0;

        #2;
        push_exp("reset", 4'b0000, 1'b0, 1'b0, 1'b0, 16'd0);
        check_next();
        @(posedge clk);
        #1;
        @(posedge clk);
        #1;
        rst_n = 1'b1;

        // Forwarding selection
        set_in(5'd6, 5'd5, 2'b11, 5'd5, 1'b1, 1'b0, 5'd6, 1'b1, 1'b0);
        step("basic_fwd", 4'b0110, 1'b0, 1'b0, 1'b0, 16'd0);
        set_in(5'd5, 5'd5, 2'b11, 5'd5, 1'b1, 1'b0, 5'd5, 1'b1, 1'b0);
        step("ex_priority", 4'b1010, 1'b0, 1'b0, 1'b0, 16'd0);
        set_in(5'd6, 5'd5, 2'b10, 5'd5, 1'b1, 1'b0, 5'd6, 1'b1, 1'b0);
        step("used_mask", 4'b0100, 1'b0, 1'b0, 1'b0, 16'd0);
        set_in(5'd6, 5'd5, 2'b11, 5'd5, 1'b0, 1'b0, 5'd5, 1'b1, 1'b0);
        step("no_ex_regwrite", 4'b0001, 1'b0, 1'b0, 1'b0, 16'd0);
        set_in(5'd0, 5'd0, 2'b11, 5'd0, 1'b1, 1'b1, 5'd0, 1'b1, 1'b0);
        step("zero_reg", 4'b0000, 1'b0, 1'b0, 1'b0, 16'd0);
        set_in(5'd0, 5'd0, 2'b00, 5'd0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b0);
        step("idle", 4'b0000, 1'b0, 1'b0, 1'b0, 16'd0);

        // Load-use stall of exactly three cycles
        set_in(5'd7, 5'd3, 2'b11, 5'd7, 1'b1, 1'b1, 5'd0, 1'b0, 1'b0);
        step("load_use_s1", 4'b0000, 1'b1, 1'b1, 1'b0, 16'd0);
        step("load_use_s2", 4'b0000, 1'b1, 1'b1, 1'b0, 16'd1);
        step("load_use_s3", 4'b0000, 1'b1, 1'b1, 1'b0, 16'd2);
        set_in(5'd7, 5'd3, 2'b11, 5'd7, 1'b1, 1'b0, 5'd0, 1'b0, 1'b0);
        step("load_use_resume", 4'b1000, 1'b0, 1'b0, 1'b0, 16'd3);
        set_in(5'd0, 5'd0, 2'b00, 5'd0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b0);
        step("after_stall", 4'b0000, 1'b0, 1'b0, 1'b0, 16'd3);

        // Branch aborts a stall in its second cycle
        set_in(5'd7, 5'd3, 2'b11, 5'd7, 1'b1, 1'b1, 5'd0, 1'b0, 1'b0);
        step("br_stall_s1", 4'b0000, 1'b1, 1'b1, 1'b0, 16'd3);
        step("br_stall_s2", 4'b0000, 1'b1, 1'b1, 1'b0, 16'd4);
        set_in(5'd7, 5'd3, 2'b11, 5'd7, 1'b1, 1'b1, 5'd0, 1'b0, 1'b1);
        step("br_flush", 4'b0000, 1'b0, 1'b1, 1'b1, 16'd5);
        set_in(5'd6, 5'd5, 2'b11, 5'd5, 1'b1, 1'b0, 5'd6, 1'b1, 1'b0);
        step("br_resume", 4'b0110, 1'b0, 1'b0, 1'b0, 16'd5);

        // Branch in RUN wins over a simultaneous load-use hazard
        set_in(5'd7, 5'd3, 2'b11, 5'd7, 1'b1, 1'b1, 5'd0, 1'b0, 1'b1);
        step("br_over_hazard", 4'b0000, 1'b0, 1'b1, 1'b1, 16'd5);
        set_in(5'd0, 5'd0, 2'b00, 5'd0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b0);
        step("br_over_resume", 4'b0000, 1'b0, 1'b0, 1'b0, 16'd5);

        // Asynchronous reset in the middle of a stall
        set_in(5'd7, 5'd3, 2'b11, 5'd7, 1'b1, 1'b1, 5'd0, 1'b0, 1'b0);
        step("rst_stall_s1", 4'b0000, 1'b1, 1'b1, 1'b0, 16'd5);
        #2;
        rst_n = 1'b0;
        #1;
        push_exp("rst_async", 4'b0000, 1'b0, 1'b0, 1'b0, 16'd0);
        check_next();
        set_in(5'd0, 5'd0, 2'b00, 5'd0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b0);
        step("rst_held", 4'b0000, 1'b0, 1'b0, 1'b0, 16'd0);
        rst_n = 1'b1;
        set_in(5'd6, 5'd5, 2'b11, 5'd5, 1'b1, 1'b0, 5'd6, 1'b1, 1'b0);
        step("rst_first_edge", 4'b0110, 1'b0, 1'b0, 1'b0, 16'd0);
        set_in(5'd0, 5'd0, 2'b00, 5'd0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b0);

        // Saturation: LOAD_LAT=1 stalls every other cycle under a constant hazard
        s_id_rs       = {5'd7, 5'd3};
        s_id_rs_used  = 2'b11;
        s_ex_rd       = 5'd7;
        s_ex_regwrite = 1'b1;
        s_ex_memread  = 1'b1;
        for (int e = 1; e <= 40; e++) begin
            @(posedge clk);
            #1;
            if (e == 1) cmp("sat.first_stall_hold", {15'd0, s_pc_hold}, 16'd1);
            if (e == 2) cmp("sat.single_cycle_stall", {15'd0, s_pc_hold}, 16'd0);
            if (e == 20) cmp("sat.count_10", {12'd0, s_stall_cycles}, 16'd10);
            if (e == 32) cmp("sat.count_no_wrap", {12'd0, s_stall_cycles}, 16'd15);
            if (e == 40) begin
                $display("[TB] saturation: 20 stalls, stall_cycles=%0d", s_stall_cycles);
                cmp("sat.count_held_15", {12'd0, s_stall_cycles}, 16'd15);
            end
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/hazard_fwd_ctrl.md
HAZARD_FWD_CTRL -- requirements
Module: hazard_fwd_ctrl

Interface
REQ-001 Parameters SHALL be: REG_ADDR_W, default 5, register address width; NUM_SRC, default 2, source operands per instruction (1..4); LOAD_LAT, default 1, load-use stall cycles (1..4); CNT_W, default 16, stall counter width.
REQ-002 The block SHALL use one clock; reset is asynchronous and active-low.
REQ-003 Ports, in order (name, direction, width, meaning):
- clk  in  1  clock, rising edge
- rst_n  in  1  asynchronous active-low reset
- id_rs  in  NUM_SRC*REG_ADDR_W  ID-stage source addresses; operand i occupies bits [i*REG_ADDR_W +: REG_ADDR_W]
- id_rs_used  in  NUM_SRC  per-operand "operand read" flag
- ex_rd, mem_rd  in  REG_ADDR_W each  destination of the instruction in EX and in MEM
- ex_regwrite, ex_memread, mem_regwrite  in  1 each  write-enable and load flags
- ex_branch_taken  in  1  branch/jump resolved taken in EX
- fwd_sel  out  2*NUM_SRC  registered forward select per operand, valid in EX
- pc_hold, if_id_hold  out  1 each  freeze PC and IF/ID
- id_ex_bubble  out  1  zero the ID/EX control bits
- if_id_flush  out  1  squash IF/ID
- stall_cycles  out  CNT_W  saturating count of stall cycles

Function
REQ-004 Select encoding SHALL be: 00 register file, 01 MEM/WB result, 10 EX/MEM result; 11 SHALL never be driven.
REQ-005 An operand SHALL match a producer only when its id_rs_used bit is set, the producer's regwrite is set, the producer's rd is nonzero, and the addresses are equal.
REQ-006 On each rising edge in RUN, fwd_sel[i] SHALL load 10 if operand i matches ex_rd, else 01 if it matches mem_rd, else 00; the EX match SHALL take priority.
REQ-007 Each operand SHALL be evaluated independently, so different operands may receive different nonzero selects in the same cycle.
REQ-008 A load-use hazard SHALL be detected when ex_memread=1 and any operand matches ex_rd.
REQ-009 FSM states SHALL be RUN, STALL and FLUSH.
REQ-010 RUN to STALL SHALL occur on a load-use hazard. On that edge the down-counter SHALL load LOAD_LAT-1 and fwd_sel SHALL load all zeros.
REQ-011 While in STALL:
- pc_hold, if_id_hold and id_ex_bubble SHALL be 1;
- fwd_sel SHALL be held at all zeros;
- the counter SHALL decrement each cycle;
- when the counter is 0, the next edge SHALL return to RUN and re-evaluate fwd_sel per REQ-006.
REQ-012 Load-use stall length SHALL therefore be exactly LOAD_LAT cycles.
REQ-013 ex_branch_taken=1 in any state SHALL force FLUSH on the next edge. This takes priority over hazard detection and aborts any STALL in progress.
REQ-014 FLUSH SHALL:
- last exactly one cycle;
- assert if_id_flush and id_ex_bubble;
- deassert both holds;
- drive fwd_sel to all zeros;
- return to RUN on the next edge.
REQ-015 In RUN, pc_hold, if_id_hold, id_ex_bubble and if_id_flush SHALL be 0.
REQ-016 All control outputs SHALL be a pure function of the registered state (Moore outputs).
REQ-017 stall_cycles SHALL increment once per cycle spent in STALL and saturate at 2^CNT_W-1 without wrapping.

Reset
REQ-018 While rst_n=0, the block SHALL be in state RUN with counter=0, fwd_sel=0 and stall_cycles=0.
REQ-019 Assertion of rst_n mid-STALL or mid-FLUSH SHALL abort that state immediately.
REQ-020 The first edge after rst_n deassertion SHALL evaluate the inputs normally.

Structure
REQ-021 The select encodings (FWD_RF, FWD_WB, FWD_MEM) and the FSM state encodings SHALL live in shared package hazard_pkg.
REQ-022 Per-operand priority comparison SHALL be a sub-module, fwd_match, instantiated NUM_SRC times.
REQ-023 The top level SHALL hold the FSM, the down-counter and the output registers.

Verification
REQ-024 Basic forward: ex_rd=5, ex_regwrite=1, rs1=5, rs2=6, mem_rd=6, mem_regwrite=1 -> after one edge, fwd_sel = {01,10}.
REQ-025 Zero register: rd=0 with regwrite=1 matching rs1=0 -> fwd_sel=00 and no stall.
REQ-026 Load-use with LOAD_LAT=3: ex_memread=1, ex_rd=7, rs2=7 ->
- holds and bubble asserted for exactly 3 cycles;
- stall_cycles=3 afterwards;
- RUN resumes.
REQ-027 Branch aborts stall: ex_branch_taken=1 pulsed in the 2nd STALL cycle -> one FLUSH cycle with if_id_flush=1, then RUN; stall_cycles=2.
REQ-028 Reset mid-stall: rst_n pulled low during STALL -> all outputs 0 asynchronously (before the next edge) and state RUN.
REQ-029 Saturation with CNT_W=4: 20 consecutive hazard stalls -> stall_cycles holds 15.
